// File: rtl/control_pkg.sv
// Shared state encoding, opcode map and ALU selects for the processor control unit.
package control_pkg;

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the datapath strobes and addresses from the IR.
// Outputs are Moore-style: a function of the present state and the (stable) IR.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned IR_W    = 16,
  parameter int unsigned DADDR_W = 8,
  parameter int unsigned RADDR_W = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [IR_W-1:0]    IR,
  output logic               PC_clr,
  output logic               PC_up,
  output logic               IR_ld,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] RF_W_addr,
  output logic               RF_W_en,
  output logic [RADDR_W-1:0] RF_Ra_addr,
  output logic [RADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]         ALU_s0,
  output logic [3:0]         CurrentState,
  output logic [3:0]         NextState,
  output logic               Halted
);

  state_t     state_q, state_d;
  logic [3:0] opcode;

  assign opcode       = IR[IR_W-1 -: 4];
  assign CurrentState = state_q;
  assign NextState    = state_d;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StInit;
    unique case (state_q)
      StInit:   state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OP_STORE: state_d = StStore;
          OP_LOAD:  state_d = StLoadA;
          OP_ADD:   state_d = StAdd;
          OP_SUB:   state_d = StSub;
          OP_HALT:  state_d = StHalt;
          default:  state_d = StNoop;
        endcase
      end
      StLoadA:  state_d = StLoadB;
      StNoop, StLoadB, StStore, StAdd, StSub: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StInit;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_ZERO;
    Halted     = 1'b0;
    unique case (state_q)
      StInit: PC_clr = 1'b1;
      StFetch: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      StDecode: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
      end
      // LoadA covers the synchronous memory read; LoadB commits the data.
      StLoadA, StLoadB: begin
        D_addr    = IR[11:4];
        RF_s      = 1'b1;
        RF_W_addr = IR[3:0];
        RF_W_en   = (state_q == StLoadB);
      end
      StStore: begin
        D_addr     = IR[7:0];
        RF_Ra_addr = IR[11:8];
        D_wr       = 1'b1;
      end
      StAdd, StSub: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        ALU_s0     = (state_q == StAdd) ? ALU_ADD : ALU_SUB;
        RF_W_en    = 1'b1;
      end
      StHalt:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- FSM controller that sequences the processor datapath: PC, instruction register, data memory, register file and ALU.
- Runs fetch/decode/execute on each clock. In the processor this clock is the debounced single-step key pulse.
- Drives all datapath strobes and addresses from the IR contents.
- Exports current and next state as 4-bit codes for the hex status display.

Parameters:
- IR_W, 16, instruction width
- DADDR_W, 8, data memory address width
- RADDR_W, 4, register file address width

Ports:
- clk  in  1  processor clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; forces Init
- IR  in  IR_W  current instruction register contents
- PC_clr  out  1  clear program counter
- PC_up  out  1  increment program counter
- IR_ld  out  1  load IR from instruction memory
- D_addr  out  DADDR_W  data memory address
- D_wr  out  1  data memory write enable
- RF_s  out  1  RF write-data select: 1 = memory read data, 0 = ALU output
- RF_W_addr  out  RADDR_W  RF write address
- RF_W_en  out  1  RF write enable
- RF_Ra_addr  out  RADDR_W  RF read port A address
- RF_Rb_addr  out  RADDR_W  RF read port B address
- ALU_s0  out  3  ALU function: 0 = zero/pass, 1 = A+B, 2 = A-B
- CurrentState  out  4  encoded present state
- NextState  out  4  encoded next state (combinational)
- Halted  out  1  high while in Halt

Behaviour:
- Interface: one clock (clk); Reset is asynchronous and active-high.
- State encoding:
  - Init=0, Fetch=1, Decode=2, Noop=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9.
  - Codes 10-15 are illegal and fall to Init on the next edge.
- Opcodes (IR[15:12]): NOOP=0, STORE=1, LOAD=2, ADD=3, SUB=4, HALT=5. Opcodes 6-15 execute as NOOP.
- Transitions:
  - Init->Fetch; Fetch->Decode.
  - Decode->{Noop, Store, LoadA, Add, Sub, Halt} by opcode.
  - LoadA->LoadB.
  - Noop, LoadB, Store, Add, Sub ->Fetch.
  - Halt->Halt until Reset.
- Outputs are Moore-style, a function of state plus IR. Every output is 0 unless listed below.
  - Init: PC_clr=1.
  - Fetch: IR_ld=1, PC_up=1. Both in the same cycle; the PC update is visible on the next instruction.
  - Decode: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4] (pre-drive read ports); no strobes.
  - LoadA: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. Covers the 1-cycle synchronous memory read latency.
  - LoadB: same addresses as LoadA, plus RF_W_en=1.
  - Store: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1.
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], ALU_s0=1, RF_s=0, RF_W_en=1.
  - Sub: as Add, with ALU_s0=2.
  - Halt: Halted=1; no strobes.
- Reset:
  - While Reset=1: state=Init, CurrentState=0, PC_clr=1, all other outputs 0 except NextState=1.
  - Reset mid-instruction (for example in LoadA) aborts immediately with no further write strobes.
- Latency in clocks: NOOP/STORE/ADD/SUB take 3 (Fetch, Decode, Exec); LOAD takes 4.
- Write strobes (D_wr, RF_W_en) are each high for exactly one cycle per instruction.
- IR changes only on the edge leaving Fetch, so IR is stable through Decode and execute.

Decomposition:
- Package control_pkg holds:
  - state_t enum with the 4-bit codes above;
  - opcode localparams OP_NOOP..OP_HALT;
  - ALU select localparams ALU_ZERO=0, ALU_ADD=1, ALU_SUB=2.
- No sub-module. Implement as one state register (always_ff), one next-state always_comb and one output always_comb.

Test Plan:
- Reset=1 asynchronously between edges -> CurrentState=0 and PC_clr=1 at once. Release, 1 clk -> CurrentState=1, IR_ld=1, PC_up=1.
- IR=16'h21B5 (LOAD) -> Decode, then LoadA: D_addr=8'h1B, RF_s=1, RF_W_addr=5, RF_W_en=0. Then LoadB: RF_W_en=1. Then Fetch.
- IR=16'h1320 (STORE) -> Store: D_addr=8'h20, RF_Ra_addr=3, D_wr=1 for exactly one cycle. Then Fetch.
- IR=16'h3123 (ADD) -> Ra=1, Rb=2, W=3, ALU_s0=1, RF_W_en=1. IR=16'h4123 (SUB) -> same addresses, ALU_s0=2.
- IR=16'h5000 (HALT) -> CurrentState=9 and Halted=1 for 10+ clocks with no strobes. Reset -> Init.
- IR=16'hF000 -> Noop (state 3), then Fetch. Assert Reset during LoadA -> no RF_W_en pulse ever seen.
